// File: rtl/mm_result_reader.sv
// Streams Q words from the XY memory, packs pairs into MM words, and serves
// them to a memory-mapped host through an output FIFO.
//   state | meaning
//   IDLE  | waiting for start; FIFO may still hold unread words
//   READ  | issuing XY reads and packing results into the FIFO
module mm_result_reader #(
    parameter int Q_SIZE          = 16,
    parameter int MM_SIZE         = 32,
    parameter int XY_MEM_DEPTH    = 12,
    parameter int MM_BUFFER_DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [XY_MEM_DEPTH-1:0] base_addr,
    input  logic [XY_MEM_DEPTH:0]   count,
    output logic                    busy,
    output logic                    done,
    output logic                    xy_rd_en,
    output logic [XY_MEM_DEPTH-1:0] xy_rd_addr,
    input  logic [Q_SIZE-1:0]       xy_rd_data,
    input  logic                    mm_read,
    output logic                    mm_waitrequest,
    output logic [MM_SIZE-1:0]      mm_readdata,
    output logic                    mm_readdatavalid
);
    localparam int PTR_W = $clog2(MM_BUFFER_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {IDLE, READ} state_t;

    state_t                  state_q, state_d;
    logic [XY_MEM_DEPTH-1:0] base_q, base_d;
    logic [XY_MEM_DEPTH:0]   cnt_q, cnt_d;
    logic [XY_MEM_DEPTH:0]   issued_q, issued_d;
    logic                    xy_rd_en_q, xy_rd_en_d;
    logic [XY_MEM_DEPTH-1:0] xy_rd_addr_q, xy_rd_addr_d;
    logic                    rd_odd_q, rd_odd_d;
    logic                    rd_last_q, rd_last_d;
    logic                    ret_valid_q, ret_valid_d;
    logic                    ret_odd_q, ret_odd_d;
    logic                    ret_last_q, ret_last_d;
    logic [Q_SIZE-1:0]       pack_q, pack_d;
    logic                    zero_done_q, zero_done_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [MM_SIZE-1:0]      rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;

    logic [MM_SIZE-1:0]      fifo_mem [MM_BUFFER_DEPTH];
    logic                    issue, push, pop, fifo_empty;
    logic [MM_SIZE-1:0]      push_data;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        issued_d     = issued_q;
        xy_rd_en_d   = 1'b0;
        xy_rd_addr_d = xy_rd_addr_q;
        rd_odd_d     = rd_odd_q;
        rd_last_d    = rd_last_q;
        ret_valid_d  = xy_rd_en_q;
        ret_odd_d    = rd_odd_q;
        ret_last_d   = rd_last_q;
        pack_d       = pack_q;
        zero_done_d  = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;

        fifo_empty = (occ_q == '0);
        pop        = mm_read && !fifo_empty;
        push       = ret_valid_q && (ret_odd_q || ret_last_q);
        push_data  = ret_odd_q ? {xy_rd_data, pack_q} : {{Q_SIZE{1'b0}}, xy_rd_data};
        // Threshold leaves room for the two reads already in the pipeline.
        issue      = (state_q == READ) && (issued_q < cnt_q)
                     && (occ_q <= OCC_W'(MM_BUFFER_DEPTH - 2));

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d  = READ;
                        base_d   = base_addr;
                        cnt_d    = count;
                        issued_d = '0;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (push && ret_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            xy_rd_en_d   = 1'b1;
            xy_rd_addr_d = base_q + issued_q[XY_MEM_DEPTH-1:0];
            rd_odd_d     = issued_q[0];
            rd_last_d    = ((issued_q + 1'b1) == cnt_q);
            issued_d     = issued_q + 1'b1;
        end

        if (ret_valid_q && !ret_odd_q && !ret_last_q) pack_d = xy_rd_data;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(MM_BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MM_BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            rdata_d  = fifo_mem[rd_ptr_q];
            rvalid_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            issued_q     <= '0;
            xy_rd_en_q   <= 1'b0;
            xy_rd_addr_q <= '0;
            rd_odd_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            ret_valid_q  <= 1'b0;
            ret_odd_q    <= 1'b0;
            ret_last_q   <= 1'b0;
            pack_q       <= '0;
            zero_done_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            xy_rd_en_q   <= xy_rd_en_d;
            xy_rd_addr_q <= xy_rd_addr_d;
            rd_odd_q     <= rd_odd_d;
            rd_last_q    <= rd_last_d;
            ret_valid_q  <= ret_valid_d;
            ret_odd_q    <= ret_odd_d;
            ret_last_q   <= ret_last_d;
            pack_q       <= pack_d;
            zero_done_q  <= zero_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    assign busy             = (state_q == READ);
    assign done             = (push && ret_last_q) || zero_done_q;
    assign xy_rd_en         = xy_rd_en_q;
    assign xy_rd_addr       = xy_rd_addr_q;
    assign mm_waitrequest   = fifo_empty;
    assign mm_readdata      = rdata_q;
    assign mm_readdatavalid = rvalid_q;
endmodule

// File: tb/tb_mm_result_reader.sv
// Randomized bench for mm_result_reader against a queue-based model of the
// expected read addresses and packed FIFO words.
module tb_mm_result_reader;
    logic        clk = 1'b0;
    logic        rst_n, start, mm_read;
    logic [11:0] base_addr;
    logic [12:0] count;
    logic        busy, done, xy_rd_en, mm_waitrequest, mm_readdatavalid;
    logic [11:0] xy_rd_addr;
    logic [15:0] xy_rd_data;
    logic [31:0] mm_readdata;

    mm_result_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .xy_rd_en(xy_rd_en), .xy_rd_addr(xy_rd_addr),
        .xy_rd_data(xy_rd_data), .mm_read(mm_read), .mm_waitrequest(mm_waitrequest),
        .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [4096];
    always @(posedge clk) if (xy_rd_en) xy_rd_data <= mem[xy_rd_addr];

    int          npass = 0, ntotal = 0;
    logic [31:0] exp_q[$], got_q[$];
    int          exp_addr[$], addr_q[$];
    int          done_cnt, done_nobusy, lat_err, hold_err;
    bit          pend = 1'b0;
    logic [31:0] last_data;

    task automatic clear_mon();
        exp_q.delete(); got_q.delete(); exp_addr.delete(); addr_q.delete();
        done_cnt = 0; done_nobusy = 0; lat_err = 0; hold_err = 0;
        last_data = mm_readdata;
    endtask

    // Reference: word k holds element 2k low and element 2k+1 high (zero if absent).
    task automatic model_transfer(input int base, input int cnt);
        logic [15:0] lo, hi;
        for (int i = 0; i < cnt; i += 2) begin
            lo = mem[(base + i) % 4096];
            hi = (i + 1 < cnt) ? mem[(base + i + 1) % 4096] : 16'h0000;
            exp_q.push_back({hi, lo});
        end
        for (int i = 0; i < cnt; i++) exp_addr.push_back((base + i) % 4096);
    endtask

    function automatic int word_mism();
        int m = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic int addr_mism();
        int m = 0;
        for (int i = 0; i < exp_addr.size(); i++)
            if (i >= addr_q.size() || addr_q[i] != exp_addr[i]) m++;
        return m;
    endfunction

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic step(input int rdm);
        bit rd;
        @(negedge clk);
        if (pend) begin
            if (mm_readdatavalid) got_q.push_back(mm_readdata);
            else lat_err++;
        end else begin
            if (mm_readdatavalid) lat_err++;
            if (mm_readdata !== last_data) hold_err++;
        end
        last_data = mm_readdata;
        if (done) begin
            done_cnt++;
            if (!busy) done_nobusy++;
        end
        if (xy_rd_en) addr_q.push_back(int'(xy_rd_addr));
        rd = (rdm == 2) ? bit'($urandom_range(0, 1)) : (rdm == 1);
        mm_read = rd;
        pend = rd && !mm_waitrequest;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int rdm, input int bound);
        for (int i = 0; i < bound && done_cnt < target; i++) step(rdm);
        step(rdm);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && got_q.size() < exp_q.size(); i++) step(1);
        step(0);
    endtask

    task automatic kick(input int base, input int cnt);
        base_addr = 12'(base);
        count = 13'(cnt);
        start = 1'b1;
    endtask

    task automatic test_reset();
        ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
        ntotal++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else npass++;
        ntotal++; if (xy_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", xy_rd_en); else npass++;
        ntotal++; if (xy_rd_addr !== 12'h000) $display("FAIL reset_rd_addr: got %h want 000", xy_rd_addr); else npass++;
        ntotal++; if (mm_waitrequest !== 1'b1) $display("FAIL reset_waitreq: got %b want 1", mm_waitrequest); else npass++;
        ntotal++; if (mm_readdatavalid !== 1'b0) $display("FAIL reset_rdvalid: got %b want 0", mm_readdatavalid); else npass++;
        ntotal++; if (mm_readdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", mm_readdata); else npass++;
    endtask

    task automatic test_basic();
        clear_mon();
        mem[12'h010] = 16'h1000; mem[12'h011] = 16'h2000;
        mem[12'h012] = 16'h3000; mem[12'h013] = 16'h4000;
        model_transfer(12'h010, 4);
        kick(12'h010, 4);
        step(0);
        ntotal++; if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", busy); else npass++;
        run_until_done(1, 0, 50);
        for (int i = 0; i < 5; i++) step(0);
        ntotal++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else npass++;
        ntotal++; if (done_nobusy != 0) $display("FAIL basic_busy_at_done: got %0d want 0", done_nobusy); else npass++;
        ntotal++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else npass++;
        ntotal++; if (addr_q.size() != 4 || addr_mism() != 0)
            $display("FAIL basic_addrs: got %0d reads, %0d wrong, want 4 reads 0 wrong", addr_q.size(), addr_mism()); else npass++;
        drain(100);
        ntotal++; if (got_q.size() != 2 || got_q[0] !== 32'h20001000 || got_q[1] !== 32'h40003000)
            $display("FAIL basic_words: got %0d words first %h want 2 words 20001000 40003000",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx); else npass++;
        ntotal++; if (lat_err != 0) $display("FAIL basic_latency: got %0d errors want 0", lat_err); else npass++;
    endtask

    task automatic test_wrap();
        clear_mon();
        model_transfer(12'hFFE, 3);
        kick(12'hFFE, 3);
        step(0);
        run_until_done(1, 0, 50);
        drain(100);
        ntotal++; if (addr_q.size() != 3 || addr_mism() != 0)
            $display("FAIL wrap_addrs: got %0d reads, %0d wrong, want 3 reads ffe fff 000", addr_q.size(), addr_mism()); else npass++;
        ntotal++; if (got_q.size() != 2 || got_q[1] !== {16'h0000, mem[0]})
            $display("FAIL wrap_odd_tail: got %0d words last %h want 2 words last %h",
                     got_q.size(), (got_q.size() > 1) ? got_q[1] : 32'hx, {16'h0000, mem[0]}); else npass++;
        ntotal++; if (word_mism() != 0) $display("FAIL wrap_words: got %0d mismatches want 0", word_mism()); else npass++;
    endtask

    task automatic test_backpressure();
        int b;
        clear_mon();
        b = int'($urandom_range(0, 4095));
        model_transfer(b, 80);
        kick(b, 80);
        for (int i = 0; i < 200; i++) step(0);
        ntotal++; if (addr_q.size() != 64) $display("FAIL bp_stall_reads: got %0d want 64", addr_q.size()); else npass++;
        ntotal++; if (done_cnt != 0) $display("FAIL bp_early_done: got %0d want 0", done_cnt); else npass++;
        ntotal++; if (busy !== 1'b1 || mm_waitrequest !== 1'b0)
            $display("FAIL bp_stalled_state: got busy %b waitreq %b want 1 0", busy, mm_waitrequest); else npass++;
        for (int i = 0; i < 600 && !(done_cnt >= 1 && got_q.size() >= 40); i++) step(1);
        step(0);
        ntotal++; if (got_q.size() != 40) $display("FAIL bp_word_count: got %0d want 40", got_q.size()); else npass++;
        ntotal++; if (word_mism() != 0) $display("FAIL bp_words: got %0d mismatches want 0", word_mism()); else npass++;
        ntotal++; if (addr_q.size() != 80 || addr_mism() != 0)
            $display("FAIL bp_addrs: got %0d reads, %0d wrong, want 80 reads 0 wrong", addr_q.size(), addr_mism()); else npass++;
        ntotal++; if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else npass++;
    endtask

    task automatic test_zero_and_ignore();
        int b;
        clear_mon();
        kick(12'h005, 0);
        step(0);
        ntotal++; if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL zero_done_pulse: got done %b busy %b want 1 0", done, busy); else npass++;
        step(0);
        ntotal++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else npass++;
        for (int i = 0; i < 5; i++) step(0);
        ntotal++; if (addr_q.size() != 0 || done_cnt != 1)
            $display("FAIL zero_no_reads: got %0d reads %0d dones want 0 1", addr_q.size(), done_cnt); else npass++;
        clear_mon();
        b = int'($urandom_range(0, 4095));
        model_transfer(b, 6);
        kick(b, 6);
        step(0);
        kick((b + 100) % 4096, 9);
        step(0);
        kick((b + 200) % 4096, 3);
        step(0);
        run_until_done(1, 0, 60);
        for (int i = 0; i < 5; i++) step(0);
        drain(100);
        ntotal++; if (addr_q.size() != 6 || addr_mism() != 0)
            $display("FAIL busy_start_addrs: got %0d reads, %0d wrong, want 6 reads 0 wrong", addr_q.size(), addr_mism()); else npass++;
        ntotal++; if (got_q.size() != 3 || word_mism() != 0)
            $display("FAIL busy_start_words: got %0d words %0d wrong want 3 0", got_q.size(), word_mism()); else npass++;
        ntotal++; if (done_cnt != 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt); else npass++;
    endtask

    task automatic test_continuous();
        int b, c;
        clear_mon();
        b = int'($urandom_range(0, 4095));
        c = int'($urandom_range(9, 41));
        model_transfer(b, c);
        kick(b, c);
        for (int i = 0; i < 300 && !(done_cnt >= 1 && got_q.size() >= exp_q.size()); i++) step(1);
        step(0);
        ntotal++; if (lat_err != 0) $display("FAIL cont_latency: got %0d errors want 0", lat_err); else npass++;
        ntotal++; if (hold_err != 0) $display("FAIL cont_hold: got %0d errors want 0", hold_err); else npass++;
        ntotal++; if (got_q.size() != exp_q.size() || word_mism() != 0)
            $display("FAIL cont_words: got %0d words %0d wrong want %0d 0", got_q.size(), word_mism(), exp_q.size()); else npass++;
    endtask

    task automatic test_append_random();
        int b, c;
        clear_mon();
        for (int k = 0; k < 3; k++) begin
            b = int'($urandom_range(0, 4095));
            c = int'($urandom_range(1, 40));
            model_transfer(b, c);
            kick(b, c);
            step(2);
            run_until_done(k + 1, 2, 400);
        end
        drain(400);
        ntotal++; if (done_cnt != 3) $display("FAIL append_done: got %0d want 3", done_cnt); else npass++;
        ntotal++; if (got_q.size() != exp_q.size() || word_mism() != 0)
            $display("FAIL append_words: got %0d words %0d wrong want %0d 0", got_q.size(), word_mism(), exp_q.size()); else npass++;
        ntotal++; if (addr_q.size() != exp_addr.size() || addr_mism() != 0)
            $display("FAIL append_addrs: got %0d reads %0d wrong want %0d 0", addr_q.size(), addr_mism(), exp_addr.size()); else npass++;
        ntotal++; if (lat_err != 0 || hold_err != 0)
            $display("FAIL append_protocol: got %0d latency %0d hold errors want 0 0", lat_err, hold_err); else npass++;
    endtask

    task automatic test_reset_mid();
        int b, n;
        clear_mon();
        b = int'($urandom_range(0, 4095));
        kick(b, 16);
        for (int i = 0; i < 30 && addr_q.size() < 5; i++) step(0);
        rst_n = 1'b0;
        step(0);
        ntotal++; if (busy !== 1'b0 || done !== 1'b0 || xy_rd_en !== 1'b0 || xy_rd_addr !== 12'h000)
            $display("FAIL midrst_ctrl: got busy %b done %b rd_en %b addr %h want 0 0 0 000",
                     busy, done, xy_rd_en, xy_rd_addr); else npass++;
        ntotal++; if (mm_waitrequest !== 1'b1 || mm_readdatavalid !== 1'b0 || mm_readdata !== 32'h0)
            $display("FAIL midrst_host: got waitreq %b valid %b data %h want 1 0 0",
                     mm_waitrequest, mm_readdatavalid, mm_readdata); else npass++;
        rst_n = 1'b1;
        done_cnt = 0;
        n = addr_q.size();
        for (int i = 0; i < 30; i++) step(0);
        ntotal++; if (done_cnt != 0 || addr_q.size() != n || mm_waitrequest !== 1'b1)
            $display("FAIL midrst_quiet: got %0d dones %0d new reads waitreq %b want 0 0 1",
                     done_cnt, addr_q.size() - n, mm_waitrequest); else npass++;
        clear_mon();
        b = int'($urandom_range(0, 4095));
        model_transfer(b, 5);
        kick(b, 5);
        step(0);
        run_until_done(1, 0, 60);
        drain(100);
        ntotal++; if (done_cnt != 1 || got_q.size() != 3 || word_mism() != 0)
            $display("FAIL midrst_restart: got %0d dones %0d words %0d wrong want 1 3 0",
                     done_cnt, got_q.size(), word_mism()); else npass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0; start = 1'b0; mm_read = 1'b0; base_addr = '0; count = '0;
        clear_mon();
        step(0); step(0);
        test_reset();
        rst_n = 1'b1;
        step(0);
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_continuous();
        test_append_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
